// File: rtl/hs_skid_reg.sv
// Two-entry valid/ready register slice: registered in_rdy/out_vld, one-cycle latency, full throughput.
// Optional backpressure stall counter is built when HS_SKID_REG_STATS_EN is defined.
module hs_skid_reg #(
  parameter int WIDTH    = 8,
  parameter bit PH_S_RST = 1'b1
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             s_rst,
  input  logic [WIDTH-1:0] in_dat,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic             out_vld,
  input  logic             out_rdy
`ifdef HS_SKID_REG_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_reg, main_nxt;
  logic [WIDTH-1:0] skid_reg, skid_nxt;
  logic             s_clr;
  logic             in_acc;
  logic             out_acc;

  assign s_clr   = (s_rst == PH_S_RST);

  // Handshake outputs come from the state register only, so neither out_rdy
  // nor in_vld has a combinational path to any output.
  assign out_vld = (state != EMPTY);
  assign in_rdy  = (state != FULL);
  assign out_dat = main_reg;

  assign in_acc  = in_vld & in_rdy;
  assign out_acc = out_vld & out_rdy;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case can infer a latch.
    state_nxt = state;
    main_nxt  = main_reg;
    skid_nxt  = skid_reg;
    if (s_clr) begin
      state_nxt = EMPTY;
      main_nxt  = '0;
      skid_nxt  = '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_acc) begin
            state_nxt = ONE;
            main_nxt  = in_dat;
          end
        end
        ONE: begin
          if (in_acc && out_acc) begin
            main_nxt = in_dat;
          end else if (in_acc) begin
            state_nxt = FULL;
            skid_nxt  = in_dat;
          end else if (out_acc) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_rdy is low here, so only the drain side can move.
          if (out_acc) begin
            state_nxt = ONE;
            main_nxt  = skid_reg;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // NOTE: the data registers are reset too, because out_dat must read 0 while a_rst is held.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state    <= EMPTY;
      main_reg <= '0;
      skid_reg <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
      state    <= state_nxt;
      main_reg <= main_nxt;
      skid_reg <= skid_nxt;
    end
  end

`ifdef HS_SKID_REG_STATS_EN
  // Counts cycles with a word presented but refused; saturates rather than wrapping.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      stall_cnt <= '0;
    end else if (s_clr) begin
      stall_cnt <= '0;
    end else if (out_vld && !out_rdy && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hs_skid_reg.sv
// Directed bench for hs_skid_reg: reset, streaming, skid, sync clear (both polarities),
// a bounded random handshake run against a queue scoreboard, and the optional stall counter.
module tb_hs_skid_reg;

  localparam int W = 8;

  logic         clk    = 1'b0;
  logic         a_rst  = 1'b0;
  logic         s_rst1 = 1'b0;
  logic         s_rst0 = 1'b1;
  logic [W-1:0] in_dat = '0;
  logic         in_vld = 1'b0;
  logic         out_rdy = 1'b0;

  logic         in_rdy, out_vld, in_rdy0, out_vld0;
  logic [W-1:0] out_dat, out_dat0;
`ifdef HS_SKID_REG_STATS_EN
  logic [15:0]  stall_cnt, stall_cnt0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hs_skid_reg #(.WIDTH(W), .PH_S_RST(1'b1)) dut (
    .clk      (clk),
    .a_rst    (a_rst),
    .s_rst    (s_rst1),
    .in_dat   (in_dat),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .out_dat  (out_dat),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy)
`ifdef HS_SKID_REG_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  hs_skid_reg #(.WIDTH(W), .PH_S_RST(1'b0)) dut0 (
    .clk      (clk),
    .a_rst    (a_rst),
    .s_rst    (s_rst0),
    .in_dat   (in_dat),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy0),
    .out_dat  (out_dat0),
    .out_vld  (out_vld0),
    .out_rdy  (out_rdy)
`ifdef HS_SKID_REG_STATS_EN
    ,
    .stall_cnt(stall_cnt0)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] sb[$];
    int           sent;
    int           cyc;
    int           n;
    bit           ia;
    bit           oa;

    // Reset state
    a_rst = 1'b1;
    step();
    step();
    check("rst_out_vld", 16'(out_vld), 16'd0);
    check("rst_in_rdy", 16'(in_rdy), 16'd1);
    check("rst_out_dat", 16'(out_dat), 16'd0);
`ifdef HS_SKID_REG_STATS_EN
    check("rst_stall_cnt", stall_cnt, 16'd0);
`endif
    a_rst = 1'b0;
    step();
    check("rst_hold_out_vld", 16'(out_vld), 16'd0);
    check("rst_hold_in_rdy", 16'(in_rdy), 16'd1);

    // Streaming 0x01..0x10 with out_rdy high
    out_rdy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_vld = 1'b1;
      in_dat = 8'(i);
      check("stream_in_rdy", 16'(in_rdy), 16'd1);
      step();
      check("stream_out_vld", 16'(out_vld), 16'd1);
      check("stream_out_dat", 16'(out_dat), 16'(i));
    end
    in_vld = 1'b0;
    step();
    check("stream_drained", 16'(out_vld), 16'd0);

    // Skid: 0xA5 then 0x5A with out_rdy dropped in the 0x5A accept cycle
    in_vld = 1'b1;
    in_dat = 8'hA5;
    step();
    in_dat  = 8'h5A;
    out_rdy = 1'b0;
    step();
    in_vld = 1'b0;
    check("skid_full_in_rdy", 16'(in_rdy), 16'd0);
    check("skid_full_out_vld", 16'(out_vld), 16'd1);
    check("skid_full_out_dat", 16'(out_dat), 16'h00A5);
    step();
    check("skid_stable_out_dat", 16'(out_dat), 16'h00A5);
    check("skid_stable_in_rdy", 16'(in_rdy), 16'd0);
    out_rdy = 1'b1;
    step();
    check("skid_second_out_dat", 16'(out_dat), 16'h005A);
    check("skid_drain_in_rdy", 16'(in_rdy), 16'd1);
    step();
    check("skid_empty_out_vld", 16'(out_vld), 16'd0);

    // Asynchronous reset while FULL
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_dat  = 8'h33;
    step();
    in_dat = 8'h44;
    step();
    in_vld = 1'b0;
    check("arst_pre_in_rdy", 16'(in_rdy), 16'd0);
    #2;
    a_rst = 1'b1;
    #1;
    check("arst_out_vld", 16'(out_vld), 16'd0);
    check("arst_in_rdy", 16'(in_rdy), 16'd1);
    check("arst_out_dat", 16'(out_dat), 16'd0);
    check("arst_dut0_out_vld", 16'(out_vld0), 16'd0);
    step();
    a_rst = 1'b0;
    step();
    check("arst_hold_out_vld", 16'(out_vld), 16'd0);
    check("arst_hold_out_dat", 16'(out_dat), 16'd0);

    // Sync clear, active-high instance, with a same-cycle output accept
    in_vld = 1'b1;
    in_dat = 8'h11;
    step();
    in_dat = 8'h22;
    step();
    in_vld = 1'b0;
    check("sclr1_pre_in_rdy", 16'(in_rdy), 16'd0);
    out_rdy = 1'b1;
    s_rst1  = 1'b1;
    step();
    s_rst1 = 1'b0;
    check("sclr1_out_vld", 16'(out_vld), 16'd0);
    check("sclr1_in_rdy", 16'(in_rdy), 16'd1);
    check("sclr1_out_dat", 16'(out_dat), 16'd0);
    check("sclr1_dut0_out_dat", 16'(out_dat0), 16'h0022);
    step();
    check("sclr1_no_0x22", 16'(out_vld), 16'd0);
    check("sclr1_dut0_drained", 16'(out_vld0), 16'd0);

    // Sync clear, active-low instance
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_dat  = 8'h11;
    step();
    in_dat = 8'h22;
    step();
    in_vld = 1'b0;
    check("sclr0_pre_in_rdy", 16'(in_rdy0), 16'd0);
    out_rdy = 1'b1;
    s_rst0  = 1'b0;
    step();
    s_rst0 = 1'b1;
    check("sclr0_out_vld", 16'(out_vld0), 16'd0);
    check("sclr0_in_rdy", 16'(in_rdy0), 16'd1);
    check("sclr0_out_dat", 16'(out_dat0), 16'd0);
    check("sclr0_dut1_out_dat", 16'(out_dat), 16'h0022);
    step();
    check("sclr0_no_0x22", 16'(out_vld0), 16'd0);

    // Random handshakes against a two-entry queue model
    sent = 0;
    cyc  = 0;
    while ((sent < 400 || sb.size() != 0) && cyc < 8000) begin
      in_vld  = (sent < 400) && ($urandom_range(0, 1) == 1);
      in_dat  = 8'(sent * 7 + 3);
      out_rdy = ($urandom_range(0, 1) == 1);
      n = sb.size();
      check("rnd_out_vld", 16'(out_vld), 16'(n != 0));
      check("rnd_in_rdy", 16'(in_rdy), 16'(n != 2));
      if (n != 0) check("rnd_out_dat", 16'(out_dat), 16'(sb[0]));
      ia = in_vld && (n != 2);
      oa = out_rdy && (n != 0);
      if (oa) void'(sb.pop_front());
      if (ia) begin
        sb.push_back(in_dat);
        sent++;
      end
      step();
      cyc++;
    end
    in_vld = 1'b0;
    check("rnd_budget", 16'(cyc < 8000), 16'd1);
    check("rnd_drained", 16'(out_vld), 16'd0);

`ifdef HS_SKID_REG_STATS_EN
    // Stall counter saturation, clear, and restart
    out_rdy = 1'b0;
    s_rst1  = 1'b1;
    step();
    s_rst1 = 1'b0;
    check("stat_cleared", stall_cnt, 16'd0);
    in_vld = 1'b1;
    in_dat = 8'h77;
    step();
    in_vld = 1'b0;
    check("stat_first_load", stall_cnt, 16'd0);
    repeat (70000) @(posedge clk);
    #1;
    check("stat_saturated", stall_cnt, 16'hFFFF);
    s_rst1 = 1'b1;
    step();
    s_rst1 = 1'b0;
    check("stat_sclr", stall_cnt, 16'd0);
    in_vld = 1'b1;
    in_dat = 8'h78;
    step();
    in_vld = 1'b0;
    repeat (5) step();
    check("stat_five", stall_cnt, 16'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
